// File: rtl/display_ctrl.sv
// display_ctrl
//   Captures a 32-bit value on a display write, converts it to decimal with a
//   shift-add-3 (double-dabble) engine, one bit per cycle, and drives eight
//   active-low 7-segment digits with leading-zero blanking and an overflow flag.
//   A single pending entry absorbs back-to-back writes (latest wins).
//
//   Optional feature macro: DISPLAY_SIGNED_EN
//     defined   : display is two's complement; the magnitude is shown with a
//                 minus sign left of the most significant lit digit.
//     undefined : display is unsigned; no sign logic.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   displayflag  in   capture request, sampled every rising edge
//   display      in   [31:0] value to show when displayflag=1
//   busy         out  conversion in progress
//   done         out  one-cycle pulse after the digit outputs update
//   ovf          out  shown value does not fit in 8 digits
//   hex0..hex7   out  [6:0] segments, hex0 least significant, bit0=a..bit6=g,
//                     0 = lit
module display_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        displayflag,
   input  logic [31:0] display,
   output logic        busy,
   output logic        done,
   output logic        ovf,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5,
   output logic [6:0]  hex6,
   output logic [6:0]  hex7
);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
`ifdef DISPLAY_SIGNED_EN
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CONV   = 2'd1,
      S_UPDATE = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [4:0]   cnt_q, cnt_d;
   logic [31:0]  sr_q, sr_d;
   logic [39:0]  bcd_q, bcd_d;
   logic         pend_q, pend_d;
   logic [31:0]  pval_q, pval_d;
   logic [55:0]  hex_q, hex_d;
   logic         ovf_q, ovf_d;
   logic         done_q, done_d;
`ifdef DISPLAY_SIGNED_EN
   logic         neg_q, neg_d;
`endif

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Digit decode of the finished BCD accumulator
   logic [55:0]  dec_hex;
   logic         dec_ovf;
   int unsigned  msd;

   always_comb begin
      dec_hex = '1;
      msd     = 0;
`ifdef DISPLAY_SIGNED_EN
      // Negative values reserve hex7 for the sign, so one less digit fits
      if (neg_q) dec_ovf = |bcd_q[39:28];
      else       dec_ovf = |bcd_q[39:32];
`else
      dec_ovf = |bcd_q[39:32];
`endif
      for (int unsigned i = 0; i < 8; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) msd = i;
      end
      for (int unsigned i = 0; i < 8; i++) begin
         if (dec_ovf || i <= msd) dec_hex[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
         else                     dec_hex[7*i +: 7] = SEG_BLANK;
`ifdef DISPLAY_SIGNED_EN
         if (neg_q && !dec_ovf && i == msd + 1) dec_hex[7*i +: 7] = SEG_MINUS;
`endif
      end
   end

   // One double-dabble step: add 3 to nibbles >= 5, then shift left
   logic [39:0] bcd_adj;

   always_comb begin
      bcd_adj = bcd_q;
      for (int unsigned i = 0; i < 10; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   logic        launch;
   logic [31:0] src;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      bcd_d   = bcd_q;
      pend_d  = pend_q;
      pval_d  = pval_q;
      hex_d   = hex_q;
      ovf_d   = ovf_q;
      done_d  = (state_q == S_UPDATE);
`ifdef DISPLAY_SIGNED_EN
      neg_d   = neg_q;
`endif
      launch  = 1'b0;
      src     = display;

      case (state_q)
         S_IDLE: begin
            if (displayflag) launch = 1'b1;
         end
         S_CONV: begin
            bcd_d = {bcd_adj[38:0], sr_q[31]};
            sr_d  = {sr_q[30:0], 1'b0};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_d = S_UPDATE;
            if (displayflag) begin
               pval_d = display;
               pend_d = 1'b1;
            end
         end
         S_UPDATE: begin
            hex_d = dec_hex;
            ovf_d = dec_ovf;
            // A fresh request on this edge supersedes the stored one
            if (displayflag) begin
               launch = 1'b1;
               pend_d = 1'b0;
            end else if (pend_q) begin
               launch = 1'b1;
               src    = pval_q;
               pend_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (launch) begin
         state_d = S_CONV;
         cnt_d   = '0;
         bcd_d   = '0;
`ifdef DISPLAY_SIGNED_EN
         neg_d   = src[31];
         sr_d    = src[31] ? (~src + 32'd1) : src;
`else
         sr_d    = src;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sr_q    <= '0;
         bcd_q   <= '0;
         pend_q  <= 1'b0;
         pval_q  <= '0;
         hex_q   <= '1;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
`ifdef DISPLAY_SIGNED_EN
         neg_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         bcd_q   <= bcd_d;
         pend_q  <= pend_d;
         pval_q  <= pval_d;
         hex_q   <= hex_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
`ifdef DISPLAY_SIGNED_EN
         neg_q   <= neg_d;
`endif
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign ovf  = ovf_q;
   assign hex0 = hex_q[6:0];
   assign hex1 = hex_q[13:7];
   assign hex2 = hex_q[20:14];
   assign hex3 = hex_q[27:21];
   assign hex4 = hex_q[34:28];
   assign hex5 = hex_q[41:35];
   assign hex6 = hex_q[48:42];
   assign hex7 = hex_q[55:49];

endmodule
